// File: rtl/player_pkg.sv
// Shared types and screen constants for the per-character movement controllers.
package player_pkg;

   typedef enum logic [1:0] {SPAWN, GROUND, RISE, FALL} move_state_t;

   localparam int unsigned COORD_W      = 10;
   localparam int unsigned SCREEN_X_MIN = 0;
   localparam int unsigned SCREEN_X_MAX = 1000;
   localparam int unsigned GROUND_Y_DEF = 700;
   localparam int unsigned X_SPAWN_DEF  = 500;

endpackage

// File: rtl/player_move_ctrl_if.sv
// Keyboard-level controls in, registered sprite coordinates out.
interface player_move_ctrl_if #(
   parameter int unsigned W = player_pkg::COORD_W
) ();

   logic         left;
   logic         right;
   logic         jump;
   logic [W-1:0] pos_x;
   logic [W-1:0] pos_y;
   logic         facing;
   logic         airborne;

   modport master (output left, right, jump,
                   input  pos_x, pos_y, facing, airborne);
   modport slave  (input  left, right, jump,
                   output pos_x, pos_y, facing, airborne);

endinterface

// File: rtl/player_move_ctrl_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, shared by animation blocks.
module tick_gen #(
   parameter int unsigned DIV = 500000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/player_move_ctrl.sv
// Player position controller: saturating walk plus fixed-profile jump, updated on prescaled ticks.
module player_move_ctrl
   import player_pkg::*;
#(
   parameter int unsigned W          = COORD_W,
   parameter int unsigned X_SPAWN    = X_SPAWN_DEF,
   parameter int unsigned GROUND_Y   = GROUND_Y_DEF,
   parameter int unsigned X_MIN      = SCREEN_X_MIN,
   parameter int unsigned X_MAX      = SCREEN_X_MAX,
   parameter int unsigned STEP_X     = 1,
   parameter int unsigned STEP_Y     = 2,
   parameter int unsigned RISE_TICKS = 40,
   parameter int unsigned TICK_DIV   = 500000
) (
   input  logic                 clk,
   input  logic                 rst,
   player_move_ctrl_if.slave    mv
);

   localparam int unsigned RCW = $clog2(RISE_TICKS + 1);

   // Horizontal/vertical math is done one bit wider so limits never wrap.
   localparam logic [W:0] X_MIN_E    = (W+1)'(X_MIN);
   localparam logic [W:0] X_MAX_E    = (W+1)'(X_MAX);
   localparam logic [W:0] X_DEC_LIM  = (W+1)'(X_MIN + STEP_X);
   localparam logic [W:0] STEP_X_E   = (W+1)'(STEP_X);
   localparam logic [W:0] STEP_Y_E   = (W+1)'(STEP_Y);
   localparam logic [W:0] GROUND_Y_E = (W+1)'(GROUND_Y);

   move_state_t    state_q, state_d;
   logic [W-1:0]   pos_x_q, pos_x_d;
   logic [W-1:0]   pos_y_q, pos_y_d;
   logic           facing_q, facing_d;
   logic           airborne_q, airborne_d;
   logic           jump_q;
   logic           jump_pend_q, jump_pend_d;
   logic [RCW-1:0] rise_cnt_q, rise_cnt_d;

   logic           tick;
   logic           pend_now;
   logic [W:0]     x_ext, y_ext, x_inc, x_dec, y_up, y_down, y_sum;

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign pend_now = jump_pend_q | (mv.jump & ~jump_q);

   assign x_ext  = {1'b0, pos_x_q};
   assign y_ext  = {1'b0, pos_y_q};
   assign x_inc  = x_ext + STEP_X_E;
   assign x_dec  = x_ext - STEP_X_E;
   assign y_sum  = y_ext + STEP_Y_E;
   assign y_up   = (y_ext >= STEP_Y_E) ? (y_ext - STEP_Y_E) : '0;
   assign y_down = (y_sum >= GROUND_Y_E) ? GROUND_Y_E : y_sum;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      facing_d    = facing_q;
      rise_cnt_d  = rise_cnt_q;
      jump_pend_d = tick ? 1'b0 : pend_now;

      case (state_q)
         SPAWN: begin
            pos_x_d = W'(X_SPAWN);
            pos_y_d = W'(GROUND_Y);
            state_d = GROUND;
         end
         GROUND: begin
            if (tick && pend_now) begin
               state_d    = RISE;
               rise_cnt_d = '0;
            end
         end
         RISE: begin
            if (tick) begin
               pos_y_d    = y_up[W-1:0];
               rise_cnt_d = rise_cnt_q + RCW'(1);
               if (rise_cnt_q == RCW'(RISE_TICKS - 1)) state_d = FALL;
            end
         end
         FALL: begin
            if (tick) begin
               pos_y_d = y_down[W-1:0];
               if (y_down == GROUND_Y_E) state_d = GROUND;
            end
         end
         default: state_d = SPAWN;
      endcase

      if (tick && state_q != SPAWN) begin
         if (mv.right && !mv.left) begin
            pos_x_d  = (x_inc > X_MAX_E) ? X_MAX_E[W-1:0] : x_inc[W-1:0];
            facing_d = 1'b1;
         end else if (mv.left && !mv.right) begin
            pos_x_d  = (x_ext >= X_DEC_LIM) ? x_dec[W-1:0] : X_MIN_E[W-1:0];
            facing_d = 1'b0;
         end
      end

      airborne_d = (state_d == RISE) || (state_d == FALL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SPAWN;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         facing_q    <= 1'b1;
         airborne_q  <= 1'b0;
         jump_q      <= 1'b0;
         jump_pend_q <= 1'b0;
         rise_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         facing_q    <= facing_d;
         airborne_q  <= airborne_d;
         jump_q      <= mv.jump;
         jump_pend_q <= jump_pend_d;
         rise_cnt_q  <= rise_cnt_d;
      end
   end

   assign mv.pos_x    = pos_x_q;
   assign mv.pos_y    = pos_y_q;
   assign mv.facing   = facing_q;
   assign mv.airborne = airborne_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a 4-cycle tick and a 3-tick rise.
module tb_player_move_ctrl;

   logic clk;
   logic rst;
   int   n_asserts;
   int   n_fail;
   int   cyc;

   player_move_ctrl_if #(.W(10)) mv ();

   player_move_ctrl #(
      .W(10), .X_SPAWN(500), .GROUND_Y(700), .X_MIN(0), .X_MAX(505),
      .STEP_X(1), .STEP_Y(2), .RISE_TICKS(3), .TICK_DIV(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mv  (mv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge, sampled 1 time unit later; cyc counts edges since reset release.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Ticks land on edges where cyc is a multiple of TICK_DIV.
   task automatic to_tick();
      step();
      while (cyc % 4 != 0) step();
   endtask

   task automatic check_pos(input string tag, input int ex, input int ey, input logic eair);
      check({tag, ".x"}, 32'(mv.pos_x), 32'(ex));
      check({tag, ".y"}, 32'(mv.pos_y), 32'(ey));
      check({tag, ".air"}, 32'(mv.airborne), 32'(eair));
   endtask

   initial begin
      int ex;
      int ys  [6];
      logic air [6];
      ys  = '{698, 696, 694, 696, 698, 700};
      air = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      n_asserts = 0;
      n_fail    = 0;
      cyc       = 0;
      rst       = 1'b1;
      mv.left   = 1'b0;
      mv.right  = 1'b0;
      mv.jump   = 1'b0;

      // Reset and spawn
      step();
      step();
      check_pos("reset", 0, 0, 1'b0);
      check("reset.facing", 32'(mv.facing), 32'd1);
      rst = 1'b0;
      cyc = 0;
      step();
      check_pos("spawn", 500, 700, 1'b0);
      check("spawn.facing", 32'(mv.facing), 32'd1);

      // Walk right into the X_MAX clamp
      mv.right = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         to_tick();
         ex = (500 + k > 505) ? 505 : 500 + k;
         check($sformatf("right%0d.x", k), 32'(mv.pos_x), 32'(ex));
         check($sformatf("right%0d.facing", k), 32'(mv.facing), 32'd1);
      end
      check("right.y", 32'(mv.pos_y), 32'd700);

      // Walk left two ticks, then both keys hold position and facing
      mv.right = 1'b0;
      mv.left  = 1'b1;
      to_tick();
      check("left1.x", 32'(mv.pos_x), 32'd504);
      check("left1.facing", 32'(mv.facing), 32'd0);
      to_tick();
      check("left2.x", 32'(mv.pos_x), 32'd503);
      mv.right = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         to_tick();
         check($sformatf("both%0d.x", k), 32'(mv.pos_x), 32'd503);
         check($sformatf("both%0d.facing", k), 32'(mv.facing), 32'd0);
      end
      mv.left  = 1'b0;
      mv.right = 1'b0;

      // Single-cycle jump pulse; a press while rising is discarded
      mv.jump = 1'b1;
      step();
      mv.jump = 1'b0;
      to_tick();
      check_pos("jmp_start", 503, 700, 1'b1);
      for (int k = 0; k < 6; k++) begin
         to_tick();
         check_pos($sformatf("jmp%0d", k), 503, ys[k], air[k]);
         if (k == 1) begin
            mv.jump = 1'b1;
            step();
            mv.jump = 1'b0;
         end
      end
      to_tick();
      check_pos("jmp_air_press", 503, 700, 1'b0);

      // Jump held through landing does not retrigger
      mv.jump = 1'b1;
      to_tick();
      check_pos("hold_start", 503, 700, 1'b1);
      for (int k = 0; k < 6; k++) begin
         to_tick();
         check_pos($sformatf("hold%0d", k), 503, ys[k], air[k]);
      end
      to_tick();
      check_pos("hold_after1", 503, 700, 1'b0);
      to_tick();
      check_pos("hold_after2", 503, 700, 1'b0);

      // Release and press again starts a new jump
      mv.jump = 1'b0;
      step();
      mv.jump = 1'b1;
      step();
      mv.jump = 1'b0;
      to_tick();
      check_pos("rejump_start", 503, 700, 1'b1);
      to_tick();
      check_pos("rejump0", 503, 698, 1'b1);
      to_tick();
      check_pos("rejump1", 503, 696, 1'b1);

      // Reset mid-rise aborts the jump, then spawns on ground
      rst = 1'b1;
      step();
      check_pos("midrst", 0, 0, 1'b0);
      check("midrst.facing", 32'(mv.facing), 32'd1);
      rst = 1'b0;
      cyc = 0;
      step();
      check_pos("respawn", 500, 700, 1'b0);
      to_tick();
      check_pos("respawn_tick", 500, 700, 1'b0);
      to_tick();
      check_pos("respawn_tick2", 500, 700, 1'b0);

      // Walk left into the X_MIN clamp
      mv.left = 1'b1;
      for (int k = 1; k <= 502; k++) to_tick();
      check("xmin.x", 32'(mv.pos_x), 32'd0);
      check("xmin.facing", 32'(mv.facing), 32'd0);
      check("xmin.y", 32'(mv.pos_y), 32'd700);
      mv.left = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
